fifo_w1_r2: RTL and testbench



---
 rtl/fifo_w1_r2_pkg.sv | 18 +
 rtl/fifo_occ_counter.sv | 38 +++
 rtl/fifo_w1_r2.sv | 92 +++++++++
 tb/tb_fifo_w1_r2.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fifo_w1_r2_pkg.sv
// Shared types and helpers for the write-1 / read-2 circular buffer.
// Holds default sizing, the address-width helper and the pop-decode encoding.
package fifo_w1_r2_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2
  } pop_e;

endpackage

// File: rtl/fifo_occ_counter.sv
// Occupancy counter for the write-1 / read-2 buffer.
// Tracks 0..DEPTH entries and derives the empty/full/pair-ready flags.
module fifo_occ_counter
  import fifo_w1_r2_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CW    = addr_w(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc1,
  input  logic          dec1,
  input  logic          dec2,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          avail2
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(inc1) - CW'(dec1);
    if (dec2) cnt_d = cnt_d - CW'(2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count  = cnt_q;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign avail2 = (cnt_q >= CW'(2));

endmodule

// File: rtl/fifo_w1_r2.sv
// Circular buffer: one write per cycle, one or two show-ahead pops per cycle.
// Eligibility always uses the pre-edge occupancy, so there is no fall-through.
module fifo_w1_r2
  import fifo_w1_r2_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd1,
  input  logic              rd2,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              avail2,
  output logic              rd_err
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W-1:0] rptr_d;
  logic              wr_acc;
  logic              take1;
  logic              take2;
  logic              rej;
  pop_e              pop;

  assign wr_acc = wr_en & ~full;
  assign take2  = rd2 & avail2;
  assign take1  = ~rd2 & rd1 & ~empty;
  // rd2 never degrades to a single pop when short of a pair
  assign rej    = (rd2 & ~avail2) | (~rd2 & rd1 & empty);

  always_comb begin
    pop = POP_NONE;
    unique case (1'b1)
      take2:   pop = POP_TWO;
      take1:   pop = POP_ONE;
      default: pop = POP_NONE;
    endcase
  end

  always_comb begin
    rptr_d = rptr;
    unique case (pop)
      POP_TWO: rptr_d = rptr + ADDR_W'(2);
      POP_ONE: rptr_d = rptr + ADDR_W'(1);
      default: rptr_d = rptr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      rd_err <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ADDR_W'(1);
      rptr   <= rptr_d;
      rd_err <= rej;
    end
  end

  assign rd_data0 = mem[rptr];
  assign rd_data1 = mem[rptr + ADDR_W'(1)];

  fifo_occ_counter #(
    .DEPTH (DEPTH)
  ) u_occ (
    .clk    (clk),
    .rst    (rst),
    .inc1   (wr_acc),
    .dec1   (pop == POP_ONE),
    .dec2   (pop == POP_TWO),
    .count  (count),
    .empty  (empty),
    .full   (full),
    .avail2 (avail2)
  );

endmodule

// File: tb/tb_fifo_w1_r2.sv
// Bench for fifo_w1_r2: vector table plus a queue scoreboard of stored words.
// Hand-written sequence covers asynchronous reset between clock edges.
module tb_fifo_w1_r2;

  localparam int DW = 16;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd1;
  logic          rd2;
  logic [DW-1:0] rd_data0;
  logic [DW-1:0] rd_data1;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          avail2;
  logic          rd_err;

  int n_run  = 0;
  int n_fail = 0;

  logic [DW-1:0] q[$];

  typedef struct {
    logic          we;
    logic [DW-1:0] wd;
    logic          r1;
    logic          r2;
    int            cnt;
    logic          err;
  } vec_t;

  vec_t vt[$];

  fifo_w1_r2 #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd1      (rd1),
    .rd2      (rd2),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .avail2   (avail2),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic we, input logic [DW-1:0] wd,
                              input logic r1, input logic r2,
                              input int cnt, input logic err);
    vec_t v;
    v.we = we; v.wd = wd; v.r1 = r1; v.r2 = r2;
    v.cnt = cnt; v.err = err;
    vt.push_back(v);
  endfunction

  task automatic check_flags(input int c);
    chk("count", 32'(count), 32'(c));
    chk("empty", 32'(empty), 32'(c == 0));
    chk("full", 32'(full), 32'(c == D));
    chk("avail2", 32'(avail2), 32'(c >= 2));
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input vec_t v);
    int n;
    bit p1, p2, er;
    wr_en = v.we; wr_data = v.wd; rd1 = v.r1; rd2 = v.r2;
    #1;
    n = q.size();
    if (n >= 1) chk("rd_data0", 32'(rd_data0), 32'(q[0]));
    if (n >= 2) chk("rd_data1", 32'(rd_data1), 32'(q[1]));
    p2 = v.r2 && n >= 2;
    p1 = !v.r2 && v.r1 && n >= 1;
    er = v.r2 ? (n < 2) : (v.r1 && n == 0);
    @(posedge clk);
    if (p2) begin
      void'(q.pop_front());
      void'(q.pop_front());
    end else if (p1) begin
      void'(q.pop_front());
    end
    if (v.we && n < D) q.push_back(v.wd);
    #1;
    check_flags(v.cnt);
    chk("count_model", 32'(count), 32'(q.size()));
    chk("rd_err", 32'(rd_err), 32'(v.err));
    chk("rd_err_model", 32'(rd_err), 32'(er));
    @(negedge clk);
    wr_en = 1'b0; rd1 = 1'b0; rd2 = 1'b0;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd1 = 1'b0; rd2 = 1'b0;

    // fill 1..8, drop 9th
    for (int i = 1; i <= 8; i++) add(1, DW'(i), 0, 0, i, 0);
    add(1, 16'h0009, 0, 0, 8, 0);
    // drain in pairs
    add(0, 0, 0, 1, 6, 0);
    add(0, 0, 0, 1, 4, 0);
    add(0, 0, 0, 1, 2, 0);
    add(0, 0, 0, 1, 0, 0);
    // wrap-around
    for (int i = 0; i < 6; i++) add(1, DW'(16'h0010 + i), 0, 0, i + 1, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 5 - i, 0);
    add(1, 16'h0016, 0, 0, 2, 0);
    add(1, 16'h0017, 0, 0, 3, 0);
    add(1, 16'h0018, 0, 0, 4, 0);
    add(0, 0, 0, 1, 2, 0);
    add(1, 16'h0019, 0, 0, 3, 0);
    add(1, 16'h001A, 0, 0, 4, 0);
    add(0, 0, 0, 1, 2, 0);
    // simultaneous write and pop
    add(1, 16'h001B, 0, 0, 3, 0);
    add(1, 16'h00AA, 0, 1, 2, 0);
    add(1, 16'h00BB, 1, 0, 2, 0);
    // rejection
    add(0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0);
    add(1, 16'h00CC, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0);
    // top up to five entries
    for (int i = 0; i < 4; i++) add(1, DW'(16'h0100 + i), 0, 0, i + 2, 0);

    repeat (2) @(negedge clk);
    check_flags(0);
    chk("rd_err_reset", 32'(rd_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) step(vt[i]);

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check_flags(0);
    chk("rd_err_async", 32'(rd_err), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    v.we = 1; v.wd = 16'h1234; v.r1 = 0; v.r2 = 0; v.cnt = 1; v.err = 0;
    step(v);
    chk("rd_data0_after_reset", 32'(rd_data0), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
